// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine
// Computes result = msg^e mod n using left-to-right binary square-and-multiply.
// Each modular multiply is bit-serial (interleaved shift/add/subtract) and
// consumes one multiplier bit per cycle, so a multiply takes exactly W cycles.
// Every exponent bit costs one square plus one multiply, regardless of its
// value. This keeps the run time independent of the key.
//
// Ports:
//   clk     in   1   clock
//   reset   in   1   synchronous, active-high reset
//   start   in   1   request pulse, only sampled in IDLE
//   n       in   W   modulus, captured on accepted start
//   e       in   EW  exponent, captured on accepted start
//   msg     in   W   message/base, captured on accepted start
//   busy    out  1   high while squaring or multiplying
//   done    out  1   one-cycle pulse when result/error is valid
//   error   out  1   valid with done; operands rejected (n==0 or msg>=n)
//   result  out  W   msg^e mod n (0 on error), held until the next done
module rsa_modexp_engine #(
    parameter int W  = 128,
    parameter int EW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  n,
    input  logic [EW-1:0] e,
    input  logic [W-1:0]  msg,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [W-1:0]  result
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t         state, state_next;
    logic [W-1:0]   n_q, n_next;
    logic [EW-1:0]  e_q, e_next;
    logic [W-1:0]   base_q, base_next;
    logic [W-1:0]   r_q, r_next;
    logic [W-1:0]   acc_q, acc_next;
    logic [W-1:0]   mul_a, mul_a_next;
    logic [W-1:0]   mul_b, mul_b_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [IW-1:0]  bit_idx, bit_idx_next;
    logic           busy_next, done_next, error_next;
    logic [W-1:0]   result_next;

    // One step of the interleaved multiply. acc < n and mul_a < n, so every
    // intermediate fits in W+1 bits and one conditional subtract per step
    // is enough to bring the value back below n.
    logic [W:0]     n_ext, t_dbl, t_dbl_red, t_add;
    logic [W-1:0]   prod;
    logic [W-1:0]   r_kept;

    assign n_ext     = {1'b0, n_q};
    assign t_dbl     = {acc_q, 1'b0};
    assign t_dbl_red = (t_dbl >= n_ext) ? (t_dbl - n_ext) : t_dbl;
    assign t_add     = t_dbl_red + (mul_b[W-1] ? {1'b0, mul_a} : {(W+1){1'b0}});
    assign prod      = (t_add >= n_ext) ? W'(t_add - n_ext) : t_add[W-1:0];

    // The multiply result is always computed. For a clear exponent bit it
    // is simply not kept, so the timing stays the same for 0 and 1 bits.
    assign r_kept    = e_q[bit_idx] ? prod : r_q;

    always_comb begin
        state_next   = state;
        n_next       = n_q;
        e_next       = e_q;
        base_next    = base_q;
        r_next       = r_q;
        acc_next     = acc_q;
        mul_a_next   = mul_a;
        mul_b_next   = mul_b;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        error_next   = 1'b0;
        result_next  = result;

        case (state)
            IDLE: begin
                if (start) begin
                    n_next    = n;
                    e_next    = e;
                    base_next = msg;
                    if (n == '0 || msg >= n) begin
                        state_next  = DONE;
                        done_next   = 1'b1;
                        error_next  = 1'b1;
                        result_next = '0;
                        r_next      = '0;
                    end else begin
                        // With n==1 every residue is 0, including the empty product.
                        r_next       = (n == W'(1)) ? '0 : W'(1);
                        mul_a_next   = (n == W'(1)) ? '0 : W'(1);
                        mul_b_next   = (n == W'(1)) ? '0 : W'(1);
                        acc_next     = '0;
                        cnt_next     = CW'(W - 1);
                        bit_idx_next = IW'(EW - 1);
                        busy_next    = 1'b1;
                        state_next   = SQR;
                    end
                end
            end

            SQR: begin
                busy_next  = 1'b1;
                acc_next   = prod;
                mul_b_next = {mul_b[W-2:0], 1'b0};
                cnt_next   = cnt - CW'(1);
                if (cnt == '0) begin
                    // Square finished; set up r * base.
                    r_next     = prod;
                    mul_a_next = base_q;
                    mul_b_next = prod;
                    acc_next   = '0;
                    cnt_next   = CW'(W - 1);
                    state_next = MUL;
                end
            end

            MUL: begin
                busy_next  = 1'b1;
                acc_next   = prod;
                mul_b_next = {mul_b[W-2:0], 1'b0};
                cnt_next   = cnt - CW'(1);
                if (cnt == '0) begin
                    r_next   = r_kept;
                    acc_next = '0;
                    cnt_next = CW'(W - 1);
                    if (bit_idx == '0) begin
                        busy_next   = 1'b0;
                        done_next   = 1'b1;
                        result_next = r_kept;
                        state_next  = DONE;
                    end else begin
                        bit_idx_next = bit_idx - IW'(1);
                        mul_a_next   = r_kept;
                        mul_b_next   = r_kept;
                        state_next   = SQR;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            n_q     <= '0;
            e_q     <= '0;
            base_q  <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_next;
            n_q     <= n_next;
            e_q     <= e_next;
            base_q  <= base_next;
            r_q     <= r_next;
            acc_q   <= acc_next;
            mul_a   <= mul_a_next;
            mul_b   <= mul_b_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            busy    <= busy_next;
            done    <= done_next;
            error   <= error_next;
            result  <= result_next;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb_rsa_modexp_engine
// Directed bench for rsa_modexp_engine. Three instances: W=8/EW=4 (sel 0),
// W=8/EW=8 (sel 1) and the default W=128/EW=32 (sel 2). Small cases use
// hand-computed values. Wide cases use a % based reference model.
module tb_rsa_modexp_engine;

    logic clk;
    logic reset;

    logic         s4, s8, s128;
    logic [7:0]   n4, msg4, n8, msg8, e8;
    logic [3:0]   e4;
    logic [127:0] n128, msg128;
    logic [31:0]  e128;

    logic         busy4, done4, err4;
    logic [7:0]   res4;
    logic         busy8, done8, err8;
    logic [7:0]   res8;
    logic         busy128, done128, err128;
    logic [127:0] res128;

    int checks;
    int errors;

    rsa_modexp_engine #(.W(8), .EW(4)) u_w8e4 (
        .clk(clk), .reset(reset), .start(s4), .n(n4), .e(e4), .msg(msg4),
        .busy(busy4), .done(done4), .error(err4), .result(res4)
    );

    rsa_modexp_engine #(.W(8), .EW(8)) u_w8e8 (
        .clk(clk), .reset(reset), .start(s8), .n(n8), .e(e8), .msg(msg8),
        .busy(busy8), .done(done8), .error(err8), .result(res8)
    );

    rsa_modexp_engine u_w128 (
        .clk(clk), .reset(reset), .start(s128), .n(n128), .e(e128), .msg(msg128),
        .busy(busy128), .done(done128), .error(err128), .result(res128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] modexp_ref(input logic [127:0] nn,
                                                input logic [31:0] ee,
                                                input logic [127:0] mm);
        logic [255:0] r, b, m;
        m = {128'd0, nn};
        b = {128'd0, mm};
        r = (nn == 128'd1) ? 256'd0 : 256'd1;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % m;
            if (ee[i]) r = (r * b) % m;
        end
        return r[127:0];
    endfunction

    task automatic drive(input int sel, input logic [127:0] nn,
                         input logic [31:0] ee, input logic [127:0] mm);
        case (sel)
            0: begin s4 = 1'b1; n4 = nn[7:0]; e4 = ee[3:0]; msg4 = mm[7:0]; end
            1: begin s8 = 1'b1; n8 = nn[7:0]; e8 = ee[7:0]; msg8 = mm[7:0]; end
            default: begin s128 = 1'b1; n128 = nn; e128 = ee; msg128 = mm; end
        endcase
    endtask

    task automatic clear_start();
        s4 = 1'b0; s8 = 1'b0; s128 = 1'b0;
    endtask

    task automatic peek(input int sel, output logic b, output logic d,
                        output logic er, output logic [127:0] r);
        case (sel)
            0: begin b = busy4; d = done4; er = err4; r = {120'd0, res4}; end
            1: begin b = busy8; d = done8; er = err8; r = {120'd0, res8}; end
            default: begin b = busy128; d = done128; er = err128; r = res128; end
        endcase
    endtask

    // Starts one operation and waits (bounded) for done. lat is the cycle in
    // which done is seen, counting the start cycle as 0; -1 on timeout.
    task automatic run_op(input int sel, input logic [127:0] nn, input logic [31:0] ee,
                          input logic [127:0] mm, input int budget,
                          output logic [127:0] res, output logic err,
                          output int lat, output int busy_cnt, output int stray);
        logic b, d, er;
        logic [127:0] r;
        @(negedge clk);
        drive(sel, nn, ee, mm);
        lat = -1; busy_cnt = 0; stray = 0; res = '0; err = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            clear_start();
            peek(sel, b, d, er, r);
            if (b) busy_cnt++;
            if (er && !d) stray++;
            if (d) begin
                lat = c; res = r; err = er;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4, err4, res4} !== 11'd0) begin
            errors++; $display("FAIL reset_w8e4 got=%h want=0", {busy4, done4, err4, res4});
        end
        checks++;
        if ({busy8, done8, err8, res8} !== 11'd0) begin
            errors++; $display("FAIL reset_w8e8 got=%h want=0", {busy8, done8, err8, res8});
        end
        checks++;
        if ({busy128, done128, err128, res128} !== 131'd0) begin
            errors++; $display("FAIL reset_w128 got=%h want=0", {busy128, done128, err128, res128});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [127:0] res; logic err; int lat, bc, st;
        run_op(0, 128'd187, 32'd7, 128'd88, 100, res, err, lat, bc, st);
        checks++; if (lat !== 65) begin errors++; $display("FAIL basic_latency got=%0d want=65", lat); end
        checks++; if (res !== 128'd11) begin errors++; $display("FAIL basic_result got=%0d want=11", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_error got=%b want=0", err); end
        checks++; if (bc !== 64) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=64", bc); end
        checks++; if (st !== 0) begin errors++; $display("FAIL basic_stray_error got=%0d want=0", st); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res; logic err; int lat, bc, st;
        run_op(1, 128'd187, 32'd23, 128'd11, 200, res, err, lat, bc, st);
        checks++; if (lat !== 129) begin errors++; $display("FAIL b2b1_latency got=%0d want=129", lat); end
        checks++; if (res !== 128'd88) begin errors++; $display("FAIL b2b1_result got=%0d want=88", res); end
        checks++; if (bc !== 128) begin errors++; $display("FAIL b2b1_busy_cycles got=%0d want=128", bc); end
        run_op(1, 128'd187, 32'd0, 128'd5, 200, res, err, lat, bc, st);
        checks++; if (lat !== 129) begin errors++; $display("FAIL b2b2_latency got=%0d want=129", lat); end
        checks++; if (res !== 128'd1) begin errors++; $display("FAIL b2b2_e0_result got=%0d want=1", res); end
        run_op(1, 128'd187, 32'd3, 128'd0, 200, res, err, lat, bc, st);
        checks++; if (res !== 128'd0 || err !== 1'b0) begin
            errors++; $display("FAIL b2b3_msg0 got=%0d err=%b want=0 err=0", res, err);
        end
    endtask

    task automatic test_boundary();
        logic [127:0] res; logic err; int lat, bc, st;
        run_op(0, 128'd10, 32'd4, 128'd3, 100, res, err, lat, bc, st);
        checks++; if (res !== 128'd1 || lat !== 65) begin
            errors++; $display("FAIL even_n got=%0d lat=%0d want=1 lat=65", res, lat);
        end
        run_op(0, 128'd1, 32'd5, 128'd0, 100, res, err, lat, bc, st);
        checks++; if (res !== 128'd0 || err !== 1'b0 || lat !== 65) begin
            errors++; $display("FAIL n_is_1 got=%0d err=%b lat=%0d want=0 err=0 lat=65", res, err, lat);
        end
        run_op(0, 128'd187, 32'd3, 128'd186, 100, res, err, lat, bc, st);
        checks++; if (res !== 128'd186) begin errors++; $display("FAIL msg_n_minus_1 got=%0d want=186", res); end
        run_op(0, 128'd10, 32'd0, 128'd7, 100, res, err, lat, bc, st);
        checks++; if (res !== 128'd1) begin errors++; $display("FAIL e_zero got=%0d want=1", res); end
    endtask

    task automatic test_error();
        logic [127:0] res; logic err; int lat, bc, st;
        run_op(0, 128'd187, 32'd7, 128'd88, 100, res, err, lat, bc, st);
        run_op(0, 128'd0, 32'd7, 128'd5, 10, res, err, lat, bc, st);
        checks++; if (lat !== 1 || err !== 1'b1 || res !== 128'd0 || bc !== 0) begin
            errors++; $display("FAIL err_n0 lat=%0d err=%b res=%0d busy=%0d want 1/1/0/0", lat, err, res, bc);
        end
        run_op(0, 128'd50, 32'd7, 128'd50, 10, res, err, lat, bc, st);
        checks++; if (lat !== 1 || err !== 1'b1 || res !== 128'd0 || bc !== 0) begin
            errors++; $display("FAIL err_msg_eq_n lat=%0d err=%b res=%0d busy=%0d want 1/1/0/0", lat, err, res, bc);
        end
        run_op(0, 128'd50, 32'd7, 128'd200, 10, res, err, lat, bc, st);
        checks++; if (lat !== 1 || err !== 1'b1) begin
            errors++; $display("FAIL err_msg_gt_n lat=%0d err=%b want 1/1", lat, err);
        end
        run_op(0, 128'd187, 32'd7, 128'd88, 100, res, err, lat, bc, st);
        checks++; if (lat !== 65 || res !== 128'd11 || err !== 1'b0) begin
            errors++; $display("FAIL after_error lat=%0d res=%0d err=%b want 65/11/0", lat, res, err);
        end
    endtask

    // start held high with junk on the operand inputs while busy; valid
    // operands appear only in the cycles where the engine is expected idle.
    task automatic test_start_held();
        int ndone;
        int bad;
        @(negedge clk);
        drive(0, 128'd187, 32'd7, 128'd88);
        ndone = 0; bad = 0;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (c == 65 && (res4 !== 8'd11 || err4 !== 1'b0)) bad++;
                if (c == 131 && (res4 !== 8'd8 || err4 !== 1'b0)) bad++;
                if (c != 65 && c != 131) bad++;
            end
            if (c == 66) begin
                n4 = 8'd187; e4 = 4'd3; msg4 = 8'd2;
            end else begin
                n4 = 8'($urandom); e4 = 4'($urandom); msg4 = 8'($urandom);
            end
            if (c >= 132) s4 = 1'b0;
        end
        checks++; if (ndone !== 2) begin errors++; $display("FAIL held_done_count got=%0d want=2", ndone); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL held_results bad=%0d want=0", bad); end
        clear_start();
    endtask

    task automatic test_reset_mid();
        logic [127:0] res; logic err; int lat, bc, st;
        @(negedge clk);
        drive(0, 128'd187, 32'd7, 128'd88);
        @(negedge clk);
        clear_start();
        repeat (4) @(negedge clk);
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy4); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({busy4, done4, err4, res4} !== 11'd0) begin
            errors++; $display("FAIL mid_reset got=%h want=0", {busy4, done4, err4, res4});
        end
        reset = 1'b0;
        run_op(0, 128'd187, 32'd7, 128'd88, 100, res, err, lat, bc, st);
        checks++; if (lat !== 65 || res !== 128'd11) begin
            errors++; $display("FAIL after_reset lat=%0d res=%0d want 65/11", lat, res);
        end
    endtask

    task automatic test_wide();
        logic [127:0] res, nn, mm, exp_r; logic err; int lat, bc, st;
        logic [31:0] ee;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                nn = {128{1'b1}};
                ee = 32'hFFFF_FFFF;
            end else begin
                nn = {$urandom, $urandom, $urandom, $urandom};
                if (nn < 128'd2) nn = 128'd3;
                ee = $urandom;
            end
            mm = {$urandom, $urandom, $urandom, $urandom} % nn;
            exp_r = modexp_ref(nn, ee, mm);
            run_op(2, nn, ee, mm, 8300, res, err, lat, bc, st);
            checks++; if (lat !== 8193) begin errors++; $display("FAIL wide%0d_latency got=%0d want=8193", k, lat); end
            checks++; if (res !== exp_r || err !== 1'b0) begin
                errors++; $display("FAIL wide%0d_result got=%h want=%h err=%b", k, res, exp_r, err);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        s4 = 1'b0; s8 = 1'b0; s128 = 1'b0;
        n4 = '0; e4 = '0; msg4 = '0;
        n8 = '0; e8 = '0; msg8 = '0;
        n128 = '0; e128 = '0; msg128 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_error();
        test_start_held();
        test_reset_mid();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
